ecc_scrub_ctrl: RTL
===================

# ecc_scrub_ctrl

Consumes the per-way, per-division error flags and corrected data from the cache-array Hsiao ECC decode stage. Captures one correctable-error line at a time and writes the corrected data back to the data SRAM through a req/gnt write port; the SRAM-side encoder re-encodes it. Counts correctable and uncorrectable events, raises a one-cycle interrupt pulse on uncorrectable errors, and latches the first failing index for software.

## Interface
Parameters:
- ASSOC, 1, number of ways decoded per read
- DIVISIONS, 1, ECC blocks per way
- SIZE, 1, corrected data bits per way
- INDEX_W, 8, cache set index width
- CNT_W, 16, error counter width

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- rd_valid_i  in  1  decoded read data/flags valid this cycle
- rd_index_i  in  INDEX_W  set index of the read
- data_i  in  ASSOC*SIZE  corrected data per way
- err_i  in  ASSOC*DIVISIONS*2  per division: bit0 = correctable, bit1 = uncorrectable
- scrub_req_o  out  1  write-back request
- scrub_gnt_i  in  1  write-back grant
- scrub_index_o  out  INDEX_W  write-back set index
- scrub_way_o  out  $clog2(ASSOC) (min 1)  write-back way
- scrub_data_o  out  SIZE  corrected write-back data
- corr_cnt_o  out  CNT_W  saturating correctable-event count
- uncorr_cnt_o  out  CNT_W  saturating uncorrectable-event count
- drop_cnt_o  out  CNT_W  saturating count of scrub candidates dropped while busy
- uncorr_irq_o  out  1  one-cycle pulse per uncorrectable event
- uncorr_valid_o  out  1  sticky: uncorr_index_o holds a captured index
- uncorr_index_o  out  INDEX_W  index of first uncorrectable read since clear
- clear_i  in  1  clears counters and sticky capture

## Operation
- Way flags per read: way_corr[w] = OR of bit0 over its divisions; way_unc[w] = OR of bit1.
- Correctable event: rd_valid_i and any way_corr; corr_cnt_o += 1 (one per read, not per division).
- Uncorrectable event: rd_valid_i and any way_unc; uncorr_cnt_o += 1, uncorr_irq_o pulses; if !uncorr_valid_o, latch rd_index_i and set uncorr_valid_o.
- Scrub candidate: lowest w with way_corr[w] and !way_unc[w]. Ways with any uncorrectable division are never written back.
- FSM states:
  - IDLE: candidate present → capture index, way, data_i[w] into buffer; go REQ.
  - REQ: scrub_req_o=1, outputs stable; on scrub_gnt_i → HOLD.
  - HOLD: one turnaround cycle, then IDLE.
- Candidate arriving in REQ or HOLD is not captured; drop_cnt_o += 1.
- Counters saturate at all-ones. clear_i zeroes all counters and uncorr_valid_o/uncorr_index_o; on the same cycle as an increment, clear wins. clear_i does not affect the FSM.
- Reset: FSM IDLE; all outputs 0, including scrub_index_o, scrub_way_o, scrub_data_o and counters. Reset in REQ drops the pending request immediately; the write is abandoned.

## Timing
- rd_valid_i with an event at cycle t: counter updates, uncorr_irq_o, sticky capture and scrub_req_o all visible at t+1.
- scrub_req_o remains high until the first cycle with scrub_gnt_i=1. The write completes that cycle; req is low at the next edge.
- With gnt at t+1, the earliest next capture is a read at t+3 (HOLD at t+2).
- scrub_gnt_i with req low is ignored.

## Configuration
- ECC_SCRUB_EN defined: FSM and write-back port as described.
- Not defined: no FSM or buffer. scrub_req_o, scrub_index_o, scrub_way_o and scrub_data_o are tied 0, and drop_cnt_o stays 0. Counting, the interrupt and the sticky capture are unchanged.

## Test plan
- ASSOC=4: read index 0x12, way 2 division 0 err=01 → corr_cnt_o=1, next cycle scrub_req_o=1, scrub_way_o=2, scrub_data_o=data_i[2]. gnt after 3 cycles → req stays high through the grant cycle, then low.
- Read index 0x34 with way 1 err=10 → uncorr_irq_o high exactly 1 cycle, uncorr_cnt_o=1, uncorr_index_o=0x34; a second uncorrectable at 0x35 leaves index at 0x34; no scrub_req_o.
- Same read with way 0 err=10 and way 3 err=01 → both counters +1, scrub_way_o=3.
- Three correctable reads on consecutive cycles, gnt held low → one scrub, drop_cnt_o=2.
- CNT_W=2: five correctable reads spaced by grants → corr_cnt_o=3. clear_i together with a sixth event → 0.
- rst_i asserted while in REQ → scrub_req_o=0 next cycle; all counters 0; a new correctable read is accepted normally.

Source files
------------

// File: rtl/ecc_scrub_ctrl_if.sv
// Bundle between the ECC decode stage, the scrub write-back port and the status block of ecc_scrub_ctrl.
// Latency: none; this file only declares wires and the two views of them.
// Backpressure: the scrub request is held until scrub_gnt_i; the read side has no backpressure.
//
// Signals:
//   rd_valid_i, rd_index_i, data_i, err_i : decoded read, corrected data and per-division flags
//   scrub_req_o/scrub_gnt_i, scrub_index_o, scrub_way_o, scrub_data_o : write-back port
//   corr_cnt_o, uncorr_cnt_o, drop_cnt_o, uncorr_irq_o, uncorr_valid_o, uncorr_index_o, clear_i : status
// Modports: slave = controller view, master = driver/observer view.
interface ecc_scrub_ctrl_if #(
    parameter int ASSOC     = 1,
    parameter int DIVISIONS = 1,
    parameter int SIZE      = 1,
    parameter int INDEX_W   = 8,
    parameter int CNT_W     = 16
);
    localparam int WAY_W = (ASSOC > 1) ? $clog2(ASSOC) : 1;

    logic                          rd_valid_i;
    logic [INDEX_W-1:0]            rd_index_i;
    logic [ASSOC*SIZE-1:0]         data_i;
    logic [ASSOC*DIVISIONS*2-1:0]  err_i;

    logic                          scrub_req_o;
    logic                          scrub_gnt_i;
    logic [INDEX_W-1:0]            scrub_index_o;
    logic [WAY_W-1:0]              scrub_way_o;
    logic [SIZE-1:0]               scrub_data_o;

    logic [CNT_W-1:0]              corr_cnt_o;
    logic [CNT_W-1:0]              uncorr_cnt_o;
    logic [CNT_W-1:0]              drop_cnt_o;
    logic                          uncorr_irq_o;
    logic                          uncorr_valid_o;
    logic [INDEX_W-1:0]            uncorr_index_o;
    logic                          clear_i;

    modport slave (
        input  rd_valid_i, rd_index_i, data_i, err_i, scrub_gnt_i, clear_i,
        output scrub_req_o, scrub_index_o, scrub_way_o, scrub_data_o,
               corr_cnt_o, uncorr_cnt_o, drop_cnt_o,
               uncorr_irq_o, uncorr_valid_o, uncorr_index_o
    );

    modport master (
        output rd_valid_i, rd_index_i, data_i, err_i, scrub_gnt_i, clear_i,
        input  scrub_req_o, scrub_index_o, scrub_way_o, scrub_data_o,
               corr_cnt_o, uncorr_cnt_o, drop_cnt_o,
               uncorr_irq_o, uncorr_valid_o, uncorr_index_o
    );
endinterface

// File: rtl/ecc_scrub_ctrl.sv
// ECC scrub controller: counts correctable/uncorrectable reads and writes one corrected line back at a time.
// Latency: counters, irq, sticky capture and scrub request are all registered, visible one cycle after the read.
// Backpressure: scrub request held until granted; candidates seen while busy are dropped and counted.
//
// Ports: clk_i, rst_i (synchronous, active-high) and bus (ecc_scrub_ctrl_if.slave).
// Optional feature macro ECC_SCRUB_EN: when defined the write-back FSM and buffer are built;
// when undefined the write-back port and drop counter are tied to zero.
module ecc_scrub_ctrl #(
    parameter int ASSOC     = 1,
    parameter int DIVISIONS = 1,
    parameter int SIZE      = 1,
    parameter int INDEX_W   = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ecc_scrub_ctrl_if.slave   bus
);
    localparam int WAY_W = (ASSOC > 1) ? $clog2(ASSOC) : 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Per-way summary of the division flags (bit0 correctable, bit1 uncorrectable).
    logic [ASSOC-1:0] w_way_corr;
    logic [ASSOC-1:0] w_way_unc;

    always_comb begin
        w_way_corr = '0;
        w_way_unc  = '0;
        for (int w = 0; w < ASSOC; w++) begin
            for (int d = 0; d < DIVISIONS; d++) begin
                w_way_corr[w] = w_way_corr[w] | bus.err_i[(w*DIVISIONS+d)*2];
                w_way_unc[w]  = w_way_unc[w]  | bus.err_i[(w*DIVISIONS+d)*2+1];
            end
        end
    end

    logic w_corr_evt;
    logic w_unc_evt;
    assign w_corr_evt = bus.rd_valid_i & (|w_way_corr);
    assign w_unc_evt  = bus.rd_valid_i & (|w_way_unc);

    // Event counters, interrupt pulse and first-failure capture.
    logic [CNT_W-1:0]   r_corr_cnt;
    logic [CNT_W-1:0]   r_unc_cnt;
    logic               r_irq;
    logic               r_unc_vld;
    logic [INDEX_W-1:0] r_unc_idx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_corr_cnt <= '0;
            r_unc_cnt  <= '0;
            r_irq      <= 1'b0;
            r_unc_vld  <= 1'b0;
            r_unc_idx  <= '0;
        end else begin
            r_irq <= w_unc_evt;
            // clear takes priority over a coincident increment or capture
            if (bus.clear_i) begin
                r_corr_cnt <= '0;
                r_unc_cnt  <= '0;
                r_unc_vld  <= 1'b0;
                r_unc_idx  <= '0;
            end else begin
                if (w_corr_evt) r_corr_cnt <= sat_inc(r_corr_cnt);
                if (w_unc_evt)  r_unc_cnt  <= sat_inc(r_unc_cnt);
                if (w_unc_evt && !r_unc_vld) begin
                    r_unc_vld <= 1'b1;
                    r_unc_idx <= bus.rd_index_i;
                end
            end
        end
    end

    assign bus.corr_cnt_o     = r_corr_cnt;
    assign bus.uncorr_cnt_o   = r_unc_cnt;
    assign bus.uncorr_irq_o   = r_irq;
    assign bus.uncorr_valid_o = r_unc_vld;
    assign bus.uncorr_index_o = r_unc_idx;

`ifdef ECC_SCRUB_EN
    // Candidate: lowest way that is correctable and has no uncorrectable division.
    // Scanning downward lets the lowest qualifying way overwrite the others.
    logic             w_cand_vld;
    logic [WAY_W-1:0] w_cand_way;
    logic [SIZE-1:0]  w_cand_dat;
    logic             w_cand_fire;

    always_comb begin
        w_cand_vld = 1'b0;
        w_cand_way = '0;
        w_cand_dat = '0;
        for (int w = ASSOC-1; w >= 0; w--) begin
            if (w_way_corr[w] && !w_way_unc[w]) begin
                w_cand_vld = 1'b1;
                w_cand_way = WAY_W'(w);
                w_cand_dat = bus.data_i[w*SIZE +: SIZE];
            end
        end
    end

    assign w_cand_fire = bus.rd_valid_i & w_cand_vld;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    state_t             r_state;
    logic               r_req;
    logic [INDEX_W-1:0] r_idx;
    logic [WAY_W-1:0]   r_way;
    logic [SIZE-1:0]    r_dat;
    logic [CNT_W-1:0]   r_drop_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_idx      <= '0;
            r_way      <= '0;
            r_dat      <= '0;
            r_drop_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cand_fire) begin
                        r_idx   <= bus.rd_index_i;
                        r_way   <= w_cand_way;
                        r_dat   <= w_cand_dat;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // the write completes in the grant cycle; HOLD is the turnaround
                    if (bus.scrub_gnt_i) begin
                        r_req   <= 1'b0;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase

            // clear resets the drop count but leaves an in-flight write alone
            if (bus.clear_i) begin
                r_drop_cnt <= '0;
            end else if (w_cand_fire && (r_state != S_IDLE)) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    assign bus.scrub_req_o   = r_req;
    assign bus.scrub_index_o = r_idx;
    assign bus.scrub_way_o   = r_way;
    assign bus.scrub_data_o  = r_dat;
    assign bus.drop_cnt_o    = r_drop_cnt;
`else
    // Write-back disabled: corrected data and grant are not consumed.
    logic w_unused_dat;
    assign w_unused_dat = ^{bus.data_i, bus.scrub_gnt_i};

    assign bus.scrub_req_o   = 1'b0;
    assign bus.scrub_index_o = '0;
    assign bus.scrub_way_o   = '0;
    assign bus.scrub_data_o  = '0;
    assign bus.drop_cnt_o    = '0;
`endif

endmodule
